keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces whole-keypad frames and reports single key presses.
// Ports: clk100mhz/reset (sync, active-high); row[3:0] in (active-low, async); col[3:0] out (one bit low);
//        key_code[3:0], key_valid (1-cycle pulse), key_held, multi_key out. Report lands the cycle after the accepting frame.
module keypad_scanner #(
   parameter int SCAN_TICKS     = 100_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk100mhz,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi_key
);

   localparam int TW = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [3:0]    CNT_MAX    = 4'(DEBOUNCE_SCANS);
   localparam logic [3:0]    CNT_ACCEPT = 4'(DEBOUNCE_SCANS - 1);

   typedef enum logic [1:0] {RELEASED, PRESSED, MULTI} state_t;

   logic [3:0]    row_s1, row_s2;
   logic [TW-1:0] timer;
   logic [1:0]    col_sel;
   logic [11:0]   raw_frame;     // columns 0..2; column 3 is taken live at frame completion
   logic [15:0]   prev_frame;
   logic [15:0]   deb_frame;
   logic [3:0]    stable_cnt;
   state_t        state, state_nxt;

   logic          sample, frame_done, deb_upd, load_key;
   logic [15:0]   frame_new, deb_next;
   logic          keys_none, keys_one;
   logic [3:0]    key_idx, key_lut;

   assign col        = ~(4'b0001 << col_sel);
   assign sample     = (timer == TIMER_LAST);
   assign frame_done = sample && (col_sel == 2'd3);
   assign frame_new  = {~row_s2, raw_frame};
   // Acceptance happens exactly once, on the step that reaches saturation.
   assign deb_upd    = frame_done && (frame_new == prev_frame) && (stable_cnt == CNT_ACCEPT);
   assign deb_next   = deb_upd ? frame_new : deb_frame;

   // Row lines are asynchronous to the scan clock.
   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
      end
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         timer   <= '0;
         col_sel <= 2'd0;
      end else if (sample) begin
         timer   <= '0;
         col_sel <= col_sel + 2'd1;
      end else begin
         timer   <= timer + TW'(1);
      end
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         raw_frame  <= '0;
         prev_frame <= '0;
         deb_frame  <= '0;
         stable_cnt <= '0;
      end else if (sample) begin
         case (col_sel)
            2'd0:    raw_frame[3:0]  <= ~row_s2;
            2'd1:    raw_frame[7:4]  <= ~row_s2;
            2'd2:    raw_frame[11:8] <= ~row_s2;
            default: ;
         endcase
         if (frame_done) begin
            if (frame_new == prev_frame) begin
               if (stable_cnt != CNT_MAX)
                  stable_cnt <= stable_cnt + 4'd1;
               if (deb_upd)
                  deb_frame <= frame_new;
            end else begin
               stable_cnt <= '0;
               prev_frame <= frame_new;
            end
         end
      end
   end

   // Pattern classification: zero, exactly one, or several keys.
   assign keys_none = (deb_next == 16'd0);
   assign keys_one  = !keys_none && ((deb_next & (deb_next - 16'd1)) == 16'd0);

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++)
         if (deb_next[i])
            key_idx = 4'(i);
   end

   // Frame bit index is col*4 + row.
   always_comb begin
      case (key_idx)
         4'd0:  key_lut = 4'h1;
         4'd1:  key_lut = 4'h4;
         4'd2:  key_lut = 4'h7;
         4'd3:  key_lut = 4'h0;
         4'd4:  key_lut = 4'h2;
         4'd5:  key_lut = 4'h5;
         4'd6:  key_lut = 4'h8;
         4'd7:  key_lut = 4'hF;
         4'd8:  key_lut = 4'h3;
         4'd9:  key_lut = 4'h6;
         4'd10: key_lut = 4'h9;
         4'd11: key_lut = 4'hE;
         4'd12: key_lut = 4'hA;
         4'd13: key_lut = 4'hB;
         4'd14: key_lut = 4'hC;
         default: key_lut = 4'hD;
      endcase
   end

   always_ff @(posedge clk100mhz) begin
      if (reset)
         state <= RELEASED;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_key  = 1'b0;
      if (deb_upd) begin
         case (state)
            RELEASED: begin
               if (keys_one) begin
                  state_nxt = PRESSED;
                  load_key  = 1'b1;
               end else if (!keys_none) begin
                  state_nxt = MULTI;
               end
            end
            PRESSED, MULTI: begin
               // Any remaining key keeps the state; only full release re-arms.
               if (keys_none)
                  state_nxt = RELEASED;
            end
            default: state_nxt = RELEASED;
         endcase
      end
   end

   always_comb begin
      key_held  = (state == PRESSED);
      multi_key = (state == MULTI);
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= load_key;
         if (load_key)
            key_code <= key_lut;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level reference model of a 4x4 keypad against keypad_scanner.
// Ports: none; drives a switch matrix that reacts to col, checks every cycle.
// Stimulus changes only on frame boundaries so each frame sees one pattern.
module tb_keypad_scanner;

   localparam int ST = 4;
   localparam int DS = 2;
   localparam int FR = 4 * ST;

   logic       clk100mhz = 1'b0;
   logic       reset     = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid, key_held, multi_key;

   logic [15:0] pressed = 16'd0;   // bit col*4+row = switch closed

   keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
      .clk100mhz (clk100mhz),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held),
      .multi_key (multi_key)
   );

   always #5 clk100mhz = ~clk100mhz;

   // Switch matrix: a closed switch ties its row to its column.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[c*4+r] && !col[c])
               row[r] = 1'b0;
   end

   logic [3:0] keymap [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                     '{4'h4, 4'h5, 4'h6, 4'hB},
                                     '{4'h7, 4'h8, 4'h9, 4'hC},
                                     '{4'h0, 4'hF, 4'hE, 4'hD}};
   logic [3:0] colmap [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   int          checks = 0;
   int          errors = 0;
   int          n;
   logic [15:0] m_last;
   int          m_run;
   int          m_state;   // 0 released, 1 pressed, 2 multi
   logic [3:0]  m_code;
   logic        m_valid;
   logic        prev_valid;
   int          pulses;

   function automatic logic [15:0] key_bit(input int r, input int c);
      logic [15:0] one;
      one = 16'd1;
      return one << (c*4 + r);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      n          = 0;
      m_last     = 16'd0;
      m_run      = 1;
      m_state    = 0;
      m_code     = 4'h0;
      m_valid    = 1'b0;
      prev_valid = 1'b0;
   endtask

   // One completed frame: accept after DS+1 identical frames in a row.
   task automatic model_frame(input logic [15:0] pat);
      int k;
      if (pat == m_last) m_run++;
      else begin
         m_last = pat;
         m_run  = 1;
      end
      if (m_run == DS + 1) begin
         k = $countones(pat);
         if (m_state == 0) begin
            if (k == 1) begin
               m_state = 1;
               m_valid = 1'b1;
               for (int i = 0; i < 16; i++)
                  if (pat[i]) m_code = keymap[i % 4][i / 4];
            end else if (k > 1) begin
               m_state = 2;
            end
         end else if (k == 0) begin
            m_state = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk100mhz);
      n++;
      m_valid = 1'b0;
      if (n % FR == 0) model_frame(pressed);
      @(negedge clk100mhz);
      chk("col",       16'(col),       16'(colmap[(n / ST) % 4]));
      chk("key_valid", 16'(key_valid), 16'(m_valid));
      chk("key_code",  16'(key_code),  16'(m_code));
      chk("key_held",  16'(key_held),  16'(m_state == 1));
      chk("multi_key", 16'(multi_key), 16'(m_state == 2));
      chk("kv_consec", 16'(prev_valid & key_valid), 16'd0);
      prev_valid = key_valid;
      if (key_valid) pulses++;
   endtask

   task automatic run_frames(input logic [15:0] pat, input int nfr);
      pressed = pat;
      repeat (nfr * FR) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk100mhz);
      @(negedge clk100mhz);
      chk("rst_col",       16'(col),       16'hE);
      chk("rst_key_valid", 16'(key_valid), 16'd0);
      chk("rst_key_code",  16'(key_code),  16'd0);
      chk("rst_key_held",  16'(key_held),  16'd0);
      chk("rst_multi_key", 16'(multi_key), 16'd0);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [15:0] pat;
      int          sel;
      model_reset();
      pulses = 0;

      // Idle scan: columns rotate, nothing reported.
      do_reset();
      run_frames(16'd0, 3);
      chk("idle_pulses", 16'(pulses), 16'd0);

      // Single '5', held then released.
      pulses = 0;
      run_frames(key_bit(1, 1), 6);
      run_frames(16'd0, 4);
      chk("k5_pulses", 16'(pulses), 16'd1);

      // Bouncing 'D', then steady.
      pulses = 0;
      for (int i = 0; i < 4; i++)
         run_frames((i % 2 == 0) ? key_bit(3, 3) : 16'd0, 1);
      run_frames(key_bit(3, 3), 4);
      run_frames(16'd0, 4);
      chk("kD_pulses", 16'(pulses), 16'd1);

      // '1' and '9' together, drop '9', then release.
      pulses = 0;
      run_frames(key_bit(0, 0) | key_bit(2, 2), 4);
      run_frames(key_bit(0, 0), 4);
      run_frames(16'd0, 4);
      chk("multi_pulses", 16'(pulses), 16'd0);

      // Rollover '2' -> '2'+'C' -> 'C', then fresh 'C'.
      pulses = 0;
      run_frames(key_bit(0, 1), 4);
      run_frames(key_bit(0, 1) | key_bit(2, 3), 4);
      run_frames(key_bit(2, 3), 4);
      chk("roll_pulses", 16'(pulses), 16'd1);
      run_frames(16'd0, 4);
      run_frames(key_bit(2, 3), 4);
      run_frames(16'd0, 4);
      chk("roll_c_pulses", 16'(pulses), 16'd2);

      // Reset one frame into a '0' press, key kept down through reset.
      pulses = 0;
      run_frames(key_bit(3, 0), 1);
      do_reset();
      run_frames(key_bit(3, 0), 5);
      run_frames(16'd0, 4);
      chk("rst_k0_pulses", 16'(pulses), 16'd1);

      // Random patterns with occasional mid-frame reset.
      for (int s = 0; s < 40; s++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       pat = 16'd0;
            1:       pat = 16'd1 << $urandom_range(0, 15);
            default: pat = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         endcase
         run_frames(pat, $urandom_range(1, 5));
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, FR - 1)) step();
            do_reset();
         end
      end
      run_frames(16'd0, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
